// File: rtl/lif_pkg.sv
// Shared constants and arithmetic helpers for the leaky integrate-and-fire layer.
// Optional neuron chaining is controlled by the LIF_CHAIN_EN macro (see lif_cell).
package lif_pkg;

  localparam int RESET_ZERO = 0;
  localparam int RESET_SUB  = 1;

  function automatic int leak_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Unsigned three-term sum clamped to 2^width - 1; the 34-bit sum cannot wrap for width <= 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input int width);
    logic [33:0] sum;
    logic [33:0] max_val;
    sum     = {2'b00, a} + {2'b00, b} + {2'b00, c};
    max_val = (34'd1 << width) - 34'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter and chain flag.
// With LIF_CHAIN_EN defined, chain_in adds CHAIN_W during normal integration.
module lif_cell
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = RESET_ZERO,
  parameter int CHAIN_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic [WIDTH-1:0]           current,
  input  logic [WIDTH-1:0]           threshold,
  input  logic [leak_w(WIDTH)-1:0]   leak_shift,
  input  logic                       chain_in,
  output logic                       spike,
  output logic                       fired,
  output logic [WIDTH-1:0]           state
);

  localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RCW-1:0] RCNT_LOAD = RCW'(REFRAC);

  logic [WIDTH-1:0] state_q, state_d, leaked, integ;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic             spike_d;
  logic [31:0]      chain_add;

`ifdef LIF_CHAIN_EN
  logic fired_q;

  assign chain_add = chain_in ? 32'(CHAIN_W) : 32'd0;

  // fired stays high from a spike tick until this neuron's next tick, whatever the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fired_q <= 1'b0;
    else if (tick) fired_q <= spike_d;
  end

  assign fired = fired_q;
`else
  logic unused_chain;

  assign unused_chain = chain_in | (CHAIN_W < 0);
  assign chain_add    = 32'd0;
  assign fired        = 1'b0;
`endif

  always_comb begin
    if (32'(leak_shift) >= 32'(WIDTH)) leaked = state_q;
    else                               leaked = state_q - (state_q >> leak_shift);
  end

  assign integ = WIDTH'(sat_add(32'(leaked), 32'(current), chain_add, WIDTH));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    spike_d = 1'b0;
    if (rcnt_q != '0) begin
      rcnt_d = rcnt_q - RCW'(1);
    end else if (state_q >= threshold) begin
      spike_d = 1'b1;
      rcnt_d  = RCNT_LOAD;
      state_d = (RESET_MODE == RESET_SUB) ? state_q - threshold : '0;
    end else begin
      state_d = integ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rcnt_q  <= '0;
      spike   <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      spike   <= spike_d;
    end else begin
      spike   <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lif_array.sv
// Layer of N leaky integrate-and-fire neurons sharing threshold and leak; advances on tick.
// LIF_CHAIN_EN enables each neuron's fired flag to feed its successor.
module lif_array
  import lif_pkg::*;
#(
  parameter int N          = 4,
  parameter int WIDTH      = 8,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = RESET_ZERO,
  parameter int CHAIN_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [N*WIDTH-1:0]       current,
  input  logic [WIDTH-1:0]         threshold,
  input  logic [leak_w(WIDTH)-1:0] leak_shift,
  output logic [N-1:0]             spike,
  output logic [N*WIDTH-1:0]       state
);

  // tick is a plain per-cycle qualifier: every cycle with tick=1 is one time step; no backpressure.
  logic [N-1:0] fired;
  logic [N-1:0] chain;
  logic         unused_last;

  assign chain[0]    = 1'b0;
  assign unused_last = fired[N-1];

  for (genvar i = 1; i < N; i++) begin : g_chain
    assign chain[i] = fired[i-1];
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    lif_cell #(
      .WIDTH      (WIDTH),
      .REFRAC     (REFRAC),
      .RESET_MODE (RESET_MODE),
      .CHAIN_W    (CHAIN_W)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .current    (current[i*WIDTH +: WIDTH]),
      .threshold  (threshold),
      .leak_shift (leak_shift),
      .chain_in   (chain[i]),
      .spike      (spike[i]),
      .fired      (fired[i]),
      .state      (state[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: two instances (zero-reset and subtract-reset) share stimulus.
module tb_lif_array;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LSW = 4;
  localparam int VW  = N + N * W;
  localparam int EW  = 2 * VW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           tick = 1'b0;
  logic [N*W-1:0] current = '0;
  logic [W-1:0]   threshold = '0;
  logic [LSW-1:0] leak_shift = '0;
  logic [N-1:0]   spike_a, spike_b;
  logic [N*W-1:0] state_a, state_b;
  logic           tick_d;

  logic [EW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int n_pop = 0;

  lif_array #(.N(N), .WIDTH(W), .REFRAC(2), .RESET_MODE(0), .CHAIN_W(30)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .current(current), .threshold(threshold),
    .leak_shift(leak_shift), .spike(spike_a), .state(state_a)
  );

  lif_array #(.N(N), .WIDTH(W), .REFRAC(2), .RESET_MODE(1), .CHAIN_W(30)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .current(current), .threshold(threshold),
    .leak_shift(leak_shift), .spike(spike_b), .state(state_b)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b0;
    else        tick_d <= tick;
  end

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] s3, input logic [W-1:0] s2,
                                        input logic [W-1:0] s1, input logic [W-1:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got spike/state %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_tick(input logic [N-1:0] spa, input logic [N*W-1:0] sta,
                         input logic [N-1:0] spb, input logic [N*W-1:0] stb);
    @(posedge clk);
    #1;
    tick = 1'b1;
    exp_q.push_back({spb, stb, spa, sta});
  endtask

  task automatic do_tick2(input logic [N-1:0] sp, input logic [N*W-1:0] st);
    do_tick(sp, st, sp, st);
  endtask

  task automatic idle(input int n, input logic [N*W-1:0] st);
    @(posedge clk);
    #1;
    tick = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("idle%0d_a", k), {spike_a, state_a}, {{N{1'b0}}, st});
      check($sformatf("idle%0d_b", k), {spike_b, state_b}, {{N{1'b0}}, st});
    end
  endtask

  // Asserts reset mid-cycle right after the last tick's outputs appear.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", {spike_a, state_a}, '0);
    check("async_rst_b", {spike_b, state_b}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (tick_d) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL monitor: tick output with empty expected queue");
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        check($sformatf("tick%0d_a", n_pop), {spike_a, state_a}, e[VW-1:0]);
        check($sformatf("tick%0d_b", n_pop), {spike_b, state_b}, e[EW-1:VW]);
      end
    end
  end

  initial begin
    int k;
    #1 rst_n = 1'b0;
    #1;
    check("reset_a", {spike_a, state_a}, '0);
    check("reset_b", {spike_b, state_b}, '0);
    threshold  = 8'd30;
    leak_shift = 4'd8;
    current    = mk(0, 0, 0, 10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // integrate, tick gating, refractory, chain
    do_tick2(4'b0000, mk(0, 0, 0, 10));
    do_tick2(4'b0000, mk(0, 0, 0, 20));
    do_tick2(4'b0000, mk(0, 0, 0, 30));
    idle(5, mk(0, 0, 0, 30));
    do_tick2(4'b0001, mk(0, 0, 0, 0));
    idle(3, mk(0, 0, 0, 0));
`ifdef LIF_CHAIN_EN
    do_tick2(4'b0000, mk(0, 0, 30, 0));
    do_tick2(4'b0010, mk(0, 0, 0, 0));
    do_tick2(4'b0000, mk(0, 30, 0, 10));
`else
    do_tick2(4'b0000, mk(0, 0, 0, 0));
    do_tick2(4'b0000, mk(0, 0, 0, 0));
    do_tick2(4'b0000, mk(0, 0, 0, 10));
`endif

    // leak by halving, then full leak
    apply_reset();
    threshold  = 8'd255;
    leak_shift = 4'd1;
    current    = mk(0, 0, 0, 64);
    do_tick2(4'b0000, mk(0, 0, 0, 64));
    do_tick2(4'b0000, mk(0, 0, 0, 96));
    do_tick2(4'b0000, mk(0, 0, 0, 112));
    do_tick2(4'b0000, mk(0, 0, 0, 120));
    do_tick2(4'b0000, mk(0, 0, 0, 124));
    do_tick2(4'b0000, mk(0, 0, 0, 126));
    do_tick2(4'b0000, mk(0, 0, 0, 127));
    do_tick2(4'b0000, mk(0, 0, 0, 128));
    do_tick2(4'b0000, mk(0, 0, 0, 128));
    idle(1, mk(0, 0, 0, 128));
    leak_shift = 4'd0;
    current    = mk(0, 0, 0, 5);
    do_tick2(4'b0000, mk(0, 0, 0, 5));

    // threshold zero: every non-refractory tick spikes
    apply_reset();
    threshold  = 8'd0;
    leak_shift = 4'd8;
    current    = '0;
    do_tick2(4'b1111, mk(0, 0, 0, 0));
    do_tick2(4'b0000, mk(0, 0, 0, 0));
    do_tick2(4'b0000, mk(0, 0, 0, 0));
    do_tick2(4'b1111, mk(0, 0, 0, 0));

    // saturation and reset mode, then async reset mid-refractory
    apply_reset();
    threshold  = 8'd250;
    leak_shift = 4'd8;
    current    = mk(0, 0, 0, 200);
    do_tick2(4'b0000, mk(0, 0, 0, 200));
    do_tick2(4'b0000, mk(0, 0, 0, 255));
    do_tick(4'b0001, mk(0, 0, 0, 0), 4'b0001, mk(0, 0, 0, 5));
    apply_reset();
    do_tick2(4'b0000, mk(0, 0, 0, 200));

    // drain scoreboard
    @(posedge clk);
    #1;
    tick = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
